// File: rtl/prog_mem_pkg.sv
// Shared types and the boot image for the K2 instruction memory.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BOOT_LEN = 9;
    localparam int BOOT_W   = 8;

    localparam logic [BOOT_W-1:0] BOOT_PROG [BOOT_LEN] = '{
        8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2
    };

    // Indexed by search so callers may pass any word index; beyond the image the word is zero.
    function automatic logic [BOOT_W-1:0] boot_word(input int idx);
        logic [BOOT_W-1:0] w;
        w = '0;
        for (int k = 0; k < BOOT_LEN; k++) begin
            if (k == idx) begin
                w = BOOT_PROG[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x INST_W storage: synchronous write, registered read, reset reloads the boot image.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rdata_q;
    logic              raddr_ok;

    assign raddr_ok = ({1'b0, raddr_i} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INST_W'(boot_word(i));
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Addresses past the implemented depth read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= raddr_ok ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// K2 instruction memory: registered fetch port plus a valid/ready program loader FSM.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              inst_valid_q;
    logic              mem_we;
    logic              mem_re;

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                // A load request wins over a fetch issued in the same cycle.
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    mem_re = fetch_req;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (load_last || (ptr_q == PTR_LAST)) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            inst_valid_q <= mem_re;
        end
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (ptr_q),
        .wdata_i (load_data),
        .re_i    (mem_re),
        .raddr_i (fetch_addr),
        .rdata_o (inst)
    );

    assign inst_valid = inst_valid_q;
    assign load_ready = (state_q == LOAD);
    assign load_done  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign load_count = cnt_q;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: fetch expectations are queued, a monitor pops them on inst_valid.
module tb_prog_mem;

    localparam int ADDR_W = 4;
    localparam int INST_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [INST_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic [INST_W-1:0] exp_q [$];

    prog_mem #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every inst_valid must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (load_done) done_pulses++;
            if (inst_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got inst 0x%0h expected no valid", inst);
                end else begin
                    logic [INST_W-1:0] e;
                    e = exp_q.pop_front();
                    if (inst !== e) begin
                        errors++;
                        $display("FAIL fetch_data: got 0x%0h expected 0x%0h", inst, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(e);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [INST_W-1:0] d, input logic last);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (!load_ready && n < 20) begin
            tick();
            n++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL load_ready_timeout: got 0 expected 1");
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic drain();
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    logic [INST_W-1:0] boot [9] = '{8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2};

    initial begin
        int p0;
        repeat (3) tick();
        check("rst_inst", int'(inst), 0);
        check("rst_valid", int'(inst_valid), 0);
        check("rst_ready", int'(load_ready), 0);
        check("rst_done", int'(load_done), 0);
        check("rst_count", int'(load_count), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // 1: boot image
        for (int i = 0; i < 9; i++) fetch(ADDR_W'(i), boot[i]);
        fetch(4'd12, 8'h00);
        drain();

        // 2: short load with a gap
        p0 = done_pulses;
        start_load();
        check("t2_ready", int'(load_ready), 1);
        check("t2_busy", int'(busy), 1);
        send(8'hA1, 1'b0);
        tick();
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        check("t2_done", int'(load_done), 1);
        check("t2_ready_in_done", int'(load_ready), 0);
        check("t2_count", int'(load_count), 3);
        tick();
        check("t2_done_clear", int'(load_done), 0);
        check("t2_idle_busy", int'(busy), 0);
        check("t2_count_hold", int'(load_count), 3);
        check("t2_pulses", done_pulses - p0, 1);
        fetch(4'd0, 8'hA1);
        fetch(4'd1, 8'hA2);
        fetch(4'd2, 8'hA3);
        fetch(4'd3, 8'h10);
        drain();

        // 3: full-depth load, no load_last
        start_load();
        for (int i = 0; i < 15; i++) send(8'hF0 + 8'(i), 1'b0);
        check("t3_still_loading", int'(load_ready), 1);
        send(8'hFF, 1'b0);
        check("t3_done", int'(load_done), 1);
        check("t3_count", int'(load_count), 16);
        tick();
        fetch(4'd15, 8'hFF);
        fetch(4'd0, 8'hF0);
        fetch(4'd7, 8'hF7);
        drain();

        // 4: fetch collides with load_start, fetches during LOAD ignored
        fetch_req  = 1'b1;
        fetch_addr = 4'd2;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("t4_valid_dropped", int'(inst_valid), 0);
        check("t4_busy", int'(busy), 1);
        tick();
        tick();
        check("t4_valid_in_load", int'(inst_valid), 0);
        fetch_req = 1'b0;
        send(8'h55, 1'b1);
        tick();
        fetch(4'd0, 8'h55);
        fetch(4'd1, 8'hF1);
        drain();

        // 5: reset mid-load restores the boot image
        start_load();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        check("t5_count_before", int'(load_count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_count", int'(load_count), 0);
        check("t5_ready", int'(load_ready), 0);
        fetch(4'd0, 8'h08);
        fetch(4'd1, 8'h19);
        fetch(4'd15, 8'h00);
        drain();

        // 6: load_start repeated during LOAD is ignored
        start_load();
        send(8'h31, 1'b0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("t6_count_kept", int'(load_count), 1);
        check("t6_still_load", int'(load_ready), 1);
        send(8'h32, 1'b0);
        send(8'h33, 1'b1);
        check("t6_count", int'(load_count), 3);
        tick();
        fetch(4'd0, 8'h31);
        fetch(4'd1, 8'h32);
        fetch(4'd2, 8'h33);
        fetch(4'd3, 8'h10);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
